// File: rtl/alu_exec_ctrl.sv
// EX-stage ALU control/execute: single-cycle ALU ops plus iterative mult/div into HI/LO.
// Optional divider enabled by defining ALU_DIV_EN; otherwise div/divu decode as illegal.
module alu_exec_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       Function,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             valid_out,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef ALU_DIV_EN
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`endif

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              valid_out_q, valid_out_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              zero_q, zero_d;
    logic              illegal_q, illegal_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  work_q, work_d;
    logic [WIDTH-1:0]  opnd_q, opnd_d;
    logic              neg_q, neg_d;

    logic [WIDTH-1:0]  dec_res;
    logic              dec_ill;
    logic              dec_mul;
    logic              dec_signed;
    logic              accept;
    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;
    logic [WIDTH:0]    mul_sum;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod;

`ifdef ALU_DIV_EN
    logic              dec_div;
    logic              rneg_q, rneg_d;
    logic              dz_q, dz_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH:0]    div_shift;
    logic              div_ge;
    logic [WIDTH-1:0]  div_rem;
    logic [WIDTH-1:0]  div_quo;
`endif

    assign ready_in  = ready_q;
    assign valid_out = valid_out_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

    assign accept = valid_in && ready_q;

    always_comb begin
        dec_res    = '0;
        dec_ill    = 1'b0;
        dec_mul    = 1'b0;
        dec_signed = 1'b0;
`ifdef ALU_DIV_EN
        dec_div    = 1'b0;
`endif
        case (ALUOp)
            2'b00: dec_res = a + b;
            2'b01: dec_res = a - b;
            2'b11: dec_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: begin
                case (Function)
                    6'b100000, 6'b100001: dec_res = a + b;
                    6'b100010, 6'b100011: dec_res = a - b;
                    6'b100100: dec_res = a & b;
                    6'b100101: dec_res = a | b;
                    6'b100110: dec_res = a ^ b;
                    6'b100111: dec_res = ~(a | b);
                    6'b101010: dec_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                    6'b101011: dec_res = {{(WIDTH-1){1'b0}}, (a < b)};
                    6'b010000: dec_res = hi_q;
                    6'b010010: dec_res = lo_q;
                    6'b011000: begin dec_mul = 1'b1; dec_signed = 1'b1; end
                    6'b011001: dec_mul = 1'b1;
`ifdef ALU_DIV_EN
                    6'b011010: begin dec_div = 1'b1; dec_signed = 1'b1; end
                    6'b011011: dec_div = 1'b1;
`endif
                    default: dec_ill = 1'b1;
                endcase
            end
        endcase
    end

    assign a_mag = (dec_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag = (dec_signed && b[WIDTH-1]) ? -b : b;

    // Shift-add step: add multiplicand when the multiplier LSB is set, then shift {acc,work} right.
    assign mul_sum  = {1'b0, acc_q} + (work_q[0] ? {1'b0, opnd_q} : '0);
    assign prod_mag = {mul_sum, work_q[WIDTH-1:1]};
    assign prod     = neg_q ? -prod_mag : prod_mag;

`ifdef ALU_DIV_EN
    // Restoring step: shift next dividend bit into the remainder and subtract if it fits.
    assign div_shift = {acc_q, work_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd_q});
    assign div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, opnd_q}) : div_shift[WIDTH-1:0];
    assign div_quo   = {work_q[WIDTH-2:0], div_ge};
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ready_d     = ready_q;
        valid_out_d = 1'b0;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        acc_d       = acc_q;
        work_d      = work_q;
        opnd_d      = opnd_q;
        neg_d       = neg_q;
`ifdef ALU_DIV_EN
        rneg_d      = rneg_q;
        dz_d        = dz_q;
        a_d         = a_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (dec_mul) begin
                        state_d = MUL;
                        ready_d = 1'b0;
                        cnt_d   = CW'(WIDTH - 1);
                        acc_d   = '0;
                        work_d  = b_mag;
                        opnd_d  = a_mag;
                        neg_d   = dec_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef ALU_DIV_EN
                    end else if (dec_div) begin
                        state_d = DIV;
                        ready_d = 1'b0;
                        cnt_d   = CW'(WIDTH - 1);
                        acc_d   = '0;
                        work_d  = a_mag;
                        opnd_d  = b_mag;
                        neg_d   = dec_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        rneg_d  = dec_signed && a[WIDTH-1];
                        dz_d    = (b == '0);
                        a_d     = a;
`endif
                    end else begin
                        valid_out_d = 1'b1;
                        result_d    = dec_res;
                        zero_d      = (dec_res == '0);
                        illegal_d   = dec_ill;
                    end
                end
            end
            MUL: begin
                acc_d  = mul_sum[WIDTH:1];
                work_d = {mul_sum[0], work_q[WIDTH-1:1]};
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    valid_out_d = 1'b1;
                    hi_d        = prod[2*WIDTH-1:WIDTH];
                    lo_d        = prod[WIDTH-1:0];
                    result_d    = prod[WIDTH-1:0];
                    zero_d      = (prod[WIDTH-1:0] == '0);
                    illegal_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef ALU_DIV_EN
            DIV: begin
                acc_d  = div_rem;
                work_d = div_quo;
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    valid_out_d = 1'b1;
                    illegal_d   = 1'b0;
                    if (dz_q) begin
                        lo_d     = '1;
                        hi_d     = a_q;
                        result_d = '1;
                        zero_d   = 1'b0;
                    end else begin
                        lo_d     = neg_q ? -div_quo : div_quo;
                        hi_d     = rneg_q ? -div_rem : div_rem;
                        result_d = neg_q ? -div_quo : div_quo;
                        zero_d   = (div_quo == '0);
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            valid_out_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            acc_q       <= '0;
            work_q      <= '0;
            opnd_q      <= '0;
            neg_q       <= 1'b0;
`ifdef ALU_DIV_EN
            rneg_q      <= 1'b0;
            dz_q        <= 1'b0;
            a_q         <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            valid_out_q <= valid_out_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            acc_q       <= acc_d;
            work_q      <= work_d;
            opnd_q      <= opnd_d;
            neg_q       <= neg_d;
`ifdef ALU_DIV_EN
            rneg_q      <= rneg_d;
            dz_q        <= dz_d;
            a_q         <= a_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl (WIDTH=32); div checks follow the ALU_DIV_EN build option.
module tb_alu_exec_ctrl;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_in;
    logic          ready_in;
    logic [1:0]    ALUOp;
    logic [5:0]    Function;
    logic [W-1:0]  a, b;
    logic          valid_out;
    logic [W-1:0]  result;
    logic          zero, illegal;
    logic [W-1:0]  hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_exec_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(ready_in),
        .ALUOp(ALUOp), .Function(Function), .a(a), .b(b),
        .valid_out(valid_out), .result(result), .zero(zero), .illegal(illegal),
        .hi(hi), .lo(lo)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one request for a single edge; returns #1 after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [W-1:0] x, input logic [W-1:0] y);
        ALUOp    = op;
        Function = fn;
        a        = x;
        b        = y;
        valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    // Bounded wait for valid_out; cyc counts cycles since accept, rdy_low counts busy cycles seen.
    task automatic wait_done(output int cyc, output int rdy_low);
        cyc     = 1;
        rdy_low = 0;
        while (1) begin
            if (!ready_in) rdy_low++;
            if (valid_out || cyc >= 200) break;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        int cyc, rdy_low, pulses, seen;
        rst_n    = 1'b0;
        valid_in = 1'b0;
        ALUOp    = 2'b00;
        Function = 6'b0;
        a        = '0;
        b        = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready",   64'(ready_in),  64'd1);
        check_eq("rst_valid",   64'(valid_out), 64'd0);
        check_eq("rst_result",  64'(result),    64'd0);
        check_eq("rst_zero",    64'(zero),      64'd0);
        check_eq("rst_illegal", 64'(illegal),   64'd0);
        check_eq("rst_hi",      64'(hi),        64'd0);
        check_eq("rst_lo",      64'(lo),        64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(2'b10, 6'b100010, 32'd5, 32'd5);
        check_eq("sub_valid",  64'(valid_out), 64'd1);
        check_eq("sub_result", 64'(result),    64'd0);
        check_eq("sub_zero",   64'(zero),      64'd1);
        check_eq("sub_ill",    64'(illegal),   64'd0);
        check_eq("sub_ready",  64'(ready_in),  64'd1);

        issue(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1);
        check_eq("slt_result", 64'(result), 64'd1);
        check_eq("slt_zero",   64'(zero),   64'd0);
        issue(2'b10, 6'b101011, 32'hFFFF_FFFF, 32'd1);
        check_eq("sltu_result", 64'(result), 64'd0);
        issue(2'b00, 6'b000000, 32'hFFFF_FFFF, 32'd1);
        check_eq("add_wrap",      64'(result), 64'd0);
        check_eq("add_wrap_zero", 64'(zero),   64'd1);
        issue(2'b01, 6'b111111, 32'd3, 32'd4);
        check_eq("aluop_sub", 64'(result), 64'hFFFF_FFFF);
        check_eq("aluop_sub_ill", 64'(illegal), 64'd0);
        issue(2'b11, 6'b000000, 32'h8000_0000, 32'h7FFF_FFFF);
        check_eq("aluop_slt", 64'(result), 64'd1);
        issue(2'b10, 6'b100001, 32'd10, 32'd20);
        check_eq("addu", 64'(result), 64'd30);
        issue(2'b10, 6'b100110, 32'hFF00_FF00, 32'h0FF0_0FF0);
        check_eq("xor", 64'(result), 64'hF0F0_F0F0);
        @(posedge clk); #1;
        check_eq("pulse_end",   64'(valid_out), 64'd0);
        check_eq("result_hold", 64'(result),    64'hF0F0_F0F0);

        // Operands change right after accept; the multiply must use the latched values.
        issue(2'b10, 6'b011000, 32'hFFFF_FFFD, 32'd7);
        a = 32'h1234;
        b = 32'h55;
        wait_done(cyc, rdy_low);
        check_eq("mult_latency", 64'(cyc),     64'd33);
        check_eq("mult_busy",    64'(rdy_low), 64'd33);
        check_eq("mult_hi",      64'(hi),      64'hFFFF_FFFF);
        check_eq("mult_lo",      64'(lo),      64'hFFFF_FFEB);
        check_eq("mult_result",  64'(result),  64'hFFFF_FFEB);
        @(posedge clk); #1;
        check_eq("mult_ready_back", 64'(ready_in),  64'd1);
        check_eq("mult_one_pulse",  64'(valid_out), 64'd0);
        issue(2'b10, 6'b010000, 32'd0, 32'd0);
        check_eq("mfhi", 64'(result), 64'hFFFF_FFFF);
        issue(2'b10, 6'b010010, 32'd0, 32'd0);
        check_eq("mflo", 64'(result), 64'hFFFF_FFEB);

        // valid_in held high across a multu: exactly one accept and one valid_out.
        ALUOp    = 2'b10;
        Function = 6'b011001;
        a        = 32'hFFFF_FFFF;
        b        = 32'hFFFF_FFFF;
        valid_in = 1'b1;
        @(posedge clk); #1;
        cyc = 1;
        while (!valid_out && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        valid_in = 1'b0;
        pulses = valid_out ? 1 : 0;
        check_eq("multu_held_latency", 64'(cyc), 64'd33);
        check_eq("multu_hi", 64'(hi), 64'hFFFF_FFFE);
        check_eq("multu_lo", 64'(lo), 64'h0000_0001);
        repeat (4) begin
            @(posedge clk); #1;
            if (valid_out) pulses++;
        end
        check_eq("multu_held_pulses", 64'(pulses), 64'd1);

        ALUOp = 2'b10; Function = 6'b100000; a = 32'd1; b = 32'd2; valid_in = 1'b1;
        @(posedge clk); #1;
        check_eq("b2b_add_valid", 64'(valid_out), 64'd1);
        check_eq("b2b_add",       64'(result),    64'd3);
        Function = 6'b100101; a = 32'hF0; b = 32'h0F;
        @(posedge clk); #1;
        check_eq("b2b_or_valid", 64'(valid_out), 64'd1);
        check_eq("b2b_or",       64'(result),    64'hFF);
        Function = 6'b100111; a = 32'hF0F0_0000; b = 32'h0000_F0F0;
        @(posedge clk); #1;
        check_eq("b2b_nor_valid", 64'(valid_out), 64'd1);
        check_eq("b2b_nor",       64'(result),    64'h0F0F_0F0F);
        valid_in = 1'b0;
        @(posedge clk); #1;
        check_eq("b2b_end", 64'(valid_out), 64'd0);

        issue(2'b10, 6'b111111, 32'd1, 32'd2);
        check_eq("ill_valid",  64'(valid_out), 64'd1);
        check_eq("ill_flag",   64'(illegal),   64'd1);
        check_eq("ill_result", 64'(result),    64'd0);
        check_eq("ill_hi",     64'(hi),        64'hFFFF_FFFE);
        check_eq("ill_lo",     64'(lo),        64'h0000_0001);
        check_eq("ill_ready",  64'(ready_in),  64'd1);
        issue(2'b00, 6'b111111, 32'd2, 32'd2);
        check_eq("ill_cleared", 64'(illegal), 64'd0);

`ifdef ALU_DIV_EN
        issue(2'b10, 6'b011010, 32'hFFFF_FFF9, 32'd2);
        wait_done(cyc, rdy_low);
        check_eq("div_latency", 64'(cyc), 64'd33);
        check_eq("div_lo",      64'(lo),  64'hFFFF_FFFD);
        check_eq("div_hi",      64'(hi),  64'hFFFF_FFFF);
        @(posedge clk); #1;
        issue(2'b10, 6'b011011, 32'd7, 32'd0);
        wait_done(cyc, rdy_low);
        check_eq("divz_latency", 64'(cyc), 64'd33);
        check_eq("divz_lo",      64'(lo),  64'hFFFF_FFFF);
        check_eq("divz_hi",      64'(hi),  64'd7);
        @(posedge clk); #1;
`else
        issue(2'b10, 6'b011011, 32'd7, 32'd0);
        check_eq("divu_ill_valid",  64'(valid_out), 64'd1);
        check_eq("divu_ill_flag",   64'(illegal),   64'd1);
        check_eq("divu_ill_result", 64'(result),    64'd0);
        check_eq("divu_ill_hi",     64'(hi),        64'hFFFF_FFFE);
        check_eq("divu_ill_lo",     64'(lo),        64'h0000_0001);
        check_eq("divu_ill_ready",  64'(ready_in),  64'd1);
`endif

        // Reset lands on the edge at accept+10 of a multu.
        issue(2'b10, 6'b011001, 32'd5, 32'd6);
        repeat (9) @(posedge clk);
        #1;
        check_eq("abort_busy", 64'(ready_in), 64'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_eq("abort_ready",  64'(ready_in),  64'd1);
        check_eq("abort_valid",  64'(valid_out), 64'd0);
        check_eq("abort_hi",     64'(hi),        64'd0);
        check_eq("abort_lo",     64'(lo),        64'd0);
        check_eq("abort_result", 64'(result),    64'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid_out) seen = 1;
        end
        check_eq("abort_no_valid", 64'(seen), 64'd0);
        check_eq("abort_hi_after", 64'(hi),   64'd0);
        check_eq("abort_lo_after", 64'(lo),   64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
